// File: rtl/collatz_pkg.sv
// Shared types and constants for the Collatz engine: FSM state encoding,
// default widths, and status-bit positions used when packing into a register map.
package collatz_pkg;

  localparam int WIDTH_DEF     = 16;
  localparam int CNT_W_DEF     = 16;
  localparam int MAX_STEPS_DEF = 1000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Bit positions of the status word exposed by the Wishbone register slice
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_OVF      = 2;
  localparam int STAT_TMO      = 3;
  localparam int STAT_ERR_ZERO = 4;

endpackage

// File: rtl/collatz_engine_if.sv
// Control/result bundle between the register slice (master) and the engine (slave).
interface collatz_engine_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  import collatz_pkg::*;

  // Handshake: start is accepted only while busy=0 (IDLE) and is sampled
  // together with seed/mode on that edge; done is a one-cycle strobe that
  // qualifies x/steps/peak/flags, which then hold until the next accepted
  // start. abort ends a run silently (no done strobe).
  logic             start;
  logic [WIDTH-1:0] seed;
  logic             mode;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] x;
  logic [CNT_W-1:0] steps;
  logic [WIDTH-1:0] peak;
  logic             ovf;
  logic             tmo;
  logic             err_zero;
  state_t           dbg_state;

  modport master (
    output start, seed, mode, abort,
    input  busy, done, x, steps, peak, ovf, tmo, err_zero, dbg_state
  );

  modport slave (
    input  start, seed, mode, abort,
    output busy, done, x, steps, peak, ovf, tmo, err_zero, dbg_state
  );

endinterface

// File: rtl/collatz_step.sv
// One Collatz step, computed at WIDTH+2 bits so 3x+1 overflow is detectable
// before truncation. In shortcut mode an odd step also performs the following halving.
module collatz_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic             mode,
  output logic [WIDTH-1:0] next_x,
  output logic [1:0]       inc,
  output logic [WIDTH-1:0] peak_cand,
  output logic             overflow
);

  logic [WIDTH+1:0] x_ext;
  logic [WIDTH+1:0] t3;
  logic             odd;

  always_comb begin
    x_ext     = {2'b00, x};
    t3        = (x_ext << 1) + x_ext + (WIDTH+2)'(1);
    odd       = x[0];
    overflow  = odd && (t3[WIDTH+1:WIDTH] != 2'b00);
    next_x    = x >> 1;
    peak_cand = x >> 1;
    inc       = 2'd1;
    if (odd) begin
      // peak counts the un-halved 3x+1 even when shortcut mode skips past it
      peak_cand = t3[WIDTH-1:0];
      if (mode) begin
        next_x = t3[WIDTH:1];
        inc    = 2'd2;
      end else begin
        next_x = t3[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/collatz_engine.sv
// Collatz sequence engine: loads a seed, steps once per clock until x reaches 1,
// and reports step count, peak and termination cause (normal/overflow/timeout/zero).
module collatz_engine
  import collatz_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_STEPS = MAX_STEPS_DEF
) (
  input logic              clk,
  input logic              rst_n,
  collatz_engine_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [WIDTH-1:0] peak_q, peak_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             tmo_q, tmo_d;
  logic             err_zero_q, err_zero_d;

  logic [WIDTH-1:0] step_next_x;
  logic [1:0]       step_inc;
  logic [WIDTH-1:0] step_peak;
  logic             step_ovf;
  logic [CNT_W:0]   steps_sum;

  collatz_step #(.WIDTH(WIDTH)) u_step (
    .x         (x_q),
    .mode      (mode_q),
    .next_x    (step_next_x),
    .inc       (step_inc),
    .peak_cand (step_peak),
    .overflow  (step_ovf)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    steps_d    = steps_q;
    peak_d     = peak_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    tmo_d      = tmo_q;
    err_zero_d = err_zero_q;
    steps_sum  = {1'b0, steps_q} + (CNT_W+1)'(step_inc);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          x_d        = bus.seed;
          peak_d     = bus.seed;
          steps_d    = '0;
          ovf_d      = 1'b0;
          tmo_d      = 1'b0;
          if (bus.seed != '0) begin
            mode_d     = bus.mode;
            err_zero_d = 1'b0;
            state_d    = ST_RUN;
          end else begin
            err_zero_d = 1'b1;
            done_d     = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (x_q == WIDTH'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (steps_sum > (CNT_W+1)'(MAX_STEPS)) begin
          // the limit is checked before the step, so steps never exceeds MAX_STEPS
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
          done_d  = 1'b1;
        end else if (step_ovf) begin
          state_d = ST_IDLE;
          ovf_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          x_d     = step_next_x;
          steps_d = steps_sum[CNT_W-1:0];
          if (step_peak > peak_q) peak_d = step_peak;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      steps_q    <= '0;
      peak_q     <= '0;
      mode_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      err_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      steps_q    <= steps_d;
      peak_q     <= peak_d;
      mode_q     <= mode_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      err_zero_q <= err_zero_d;
    end
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = done_q;
  assign bus.x         = x_q;
  assign bus.steps     = steps_q;
  assign bus.peak      = peak_q;
  assign bus.ovf       = ovf_q;
  assign bus.tmo       = tmo_q;
  assign bus.err_zero  = err_zero_q;
  assign bus.dbg_state = state_q;

endmodule
